// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: opcodes, the canonical nop, the return-address register
// and the interlock FSM state encoding.
package pipeline_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;
    localparam logic [3:0]  RA_REG    = 4'd15;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        BFLUSH = 2'd2
    } il_state_e;

endpackage

// File: rtl/instr_decode.sv
// Register-usage decode of one instruction: which fields it reads and which register it writes.
// Purely combinational, zero latency, no flow control.
module instr_decode
    import pipeline_pkg::*;
(
    input  logic [31:0] instr,
    output logic        reads_rs1,
    output logic        reads_rs2,
    output logic        reads_rd,
    output logic        reads_ra,
    output logic        writes_reg,
    output logic [3:0]  dest
);

    logic [4:0] w_op;
    logic       w_imm;
    logic       w_is_nop;
    logic       w_unused_bits;

    assign w_op          = instr[31:27];
    assign w_imm         = instr[26];
    assign w_is_nop      = (w_op == NOP_INSTR[31:27]);
    assign w_unused_bits = ^instr[21:0];

    always_comb begin
        reads_rs1  = 1'b0;
        reads_rs2  = 1'b0;
        reads_rd   = 1'b0;
        reads_ra   = 1'b0;
        writes_reg = 1'b0;
        dest       = instr[25:22];
        if (!w_is_nop) begin
            case (w_op)
                OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
                OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR: begin
                    reads_rs1  = 1'b1;
                    reads_rs2  = !w_imm;
                    writes_reg = 1'b1;
                end
                // cmp reads both operands but only updates flags
                OP_CMP: begin
                    reads_rs1 = 1'b1;
                    reads_rs2 = !w_imm;
                end
                OP_NOT, OP_MOV: begin
                    reads_rs2  = !w_imm;
                    writes_reg = 1'b1;
                end
                OP_LD: begin
                    reads_rs1  = 1'b1;
                    writes_reg = 1'b1;
                end
                OP_ST: begin
                    reads_rs1 = 1'b1;
                    reads_rd  = 1'b1;
                end
                OP_CALL: begin
                    writes_reg = 1'b1;
                    dest       = RA_REG;
                end
                OP_RET: begin
                    reads_ra = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/interlock_controller.sv
// Data/branch interlock for the OF stage with saturating stall/flush counters and a sticky long-stall error.
// Interlock outputs are combinational (zero latency); INTERLOCK_FORWARDING_EN narrows hazards to load-use.
module interlock_controller
    import pipeline_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      OF_instruction,
    input  logic [31:0]      EX_instruction,
    input  logic [31:0]      MA_instruction,
    input  logic             isBranchTaken,
    output logic             isDataInterLock,
    output logic             isBranchInterLock,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_error
);

    localparam int             RUN_W     = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);

    // Index 0 = OF, 1 = EX, 2 = MA
    logic [31:0] w_instr [3];
    logic [2:0]  w_rd_rs1;
    logic [2:0]  w_rd_rs2;
    logic [2:0]  w_rd_rd;
    logic [2:0]  w_rd_ra;
    logic [2:0]  w_wr;
    logic [3:0]  w_dest [3];

    assign w_instr[0] = OF_instruction;
    assign w_instr[1] = EX_instruction;
    assign w_instr[2] = MA_instruction;

    for (genvar g = 0; g < 3; g++) begin : g_dec
        instr_decode u_dec (
            .instr      (w_instr[g]),
            .reads_rs1  (w_rd_rs1[g]),
            .reads_rs2  (w_rd_rs2[g]),
            .reads_rd   (w_rd_rd[g]),
            .reads_ra   (w_rd_ra[g]),
            .writes_reg (w_wr[g]),
            .dest       (w_dest[g])
        );
    end

    logic [3:0] w_of_rs1;
    logic [3:0] w_of_rs2;
    logic [3:0] w_of_rd;

    assign w_of_rs1 = OF_instruction[21:18];
    assign w_of_rs2 = OF_instruction[17:14];
    assign w_of_rd  = OF_instruction[25:22];

    function automatic logic src_hit(
        input logic [3:0] dst,
        input logic       use_rs1,
        input logic       use_rs2,
        input logic       use_rd,
        input logic       use_ra,
        input logic [3:0] rs1,
        input logic [3:0] rs2,
        input logic [3:0] rd
    );
        return (use_rs1 && (rs1 == dst)) ||
               (use_rs2 && (rs2 == dst)) ||
               (use_rd  && (rd  == dst)) ||
               (use_ra  && (RA_REG == dst));
    endfunction

    logic w_ex_hit;
    logic w_ma_hit;
    logic w_hazard;
    logic w_unused_dec;

    assign w_ex_hit = w_wr[1] && src_hit(w_dest[1], w_rd_rs1[0], w_rd_rs2[0], w_rd_rd[0],
                                         w_rd_ra[0], w_of_rs1, w_of_rs2, w_of_rd);
    assign w_ma_hit = w_wr[2] && src_hit(w_dest[2], w_rd_rs1[0], w_rd_rs2[0], w_rd_rd[0],
                                         w_rd_ra[0], w_of_rs1, w_of_rs2, w_of_rd);

`ifdef INTERLOCK_FORWARDING_EN
    // Everything except a load result can be bypassed to OF
    assign w_hazard     = w_ex_hit && (EX_instruction[31:27] == OP_LD);
    assign w_unused_dec = ^{w_rd_rs1[2:1], w_rd_rs2[2:1], w_rd_rd[2:1], w_rd_ra[2:1],
                            w_wr[0], w_dest[0], w_ma_hit};
`else
    assign w_hazard     = w_ex_hit || w_ma_hit;
    assign w_unused_dec = ^{w_rd_rs1[2:1], w_rd_rs2[2:1], w_rd_rd[2:1], w_rd_ra[2:1],
                            w_wr[0], w_dest[0]};
`endif

    assign isBranchInterLock = isBranchTaken;
    assign isDataInterLock   = w_hazard && !isBranchTaken;

    il_state_e        r_state;
    il_state_e        w_state_next;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = RUN;
        w_run_next   = '0;
        if (isBranchTaken) begin
            w_state_next = BFLUSH;
        end else if (isDataInterLock) begin
            w_state_next = DSTALL;
        end
        if (w_state_next == DSTALL) begin
            if (r_state != DSTALL) begin
                w_run_next = RUN_W'(1);
            end else if (r_run == RUN_LIMIT) begin
                w_run_next = r_run;
            end else begin
                w_run_next = r_run + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_run <= w_run_next;
            if (w_run_next == RUN_LIMIT) begin
                r_err <= 1'b1;
            end
            if (isDataInterLock && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (isBranchInterLock && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
    assign stall_error = r_err;

endmodule
